// File: rtl/bomb_pkg.sv
// bomb_pkg: shared types for the multi-slot bomb controller.
// Slot-state and mode enums, plus the fuse/blast counter width helper.
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        BLAST
    } slotState_t;

    typedef enum logic [1:0] {
        RUNNING,
        PAUSED,
        RESUME
    } mode_t;

    // Bits needed to hold max(fuse, blast).
    function automatic int cntWidth(input int fuse, input int blast);
        int m;
        m = (fuse > blast) ? fuse : blast;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb's IDLE/ARMED/BLAST FSM with fuse/blast counter,
// lamp phase and tile coordinates.
// Ports: clk, resetN, load (allocate this slot), tick (OneSecPulse),
//   run (global mode is RUNNING), chain (blast hit request),
//   loadX/loadY (coords to latch), busy, lamp, blast, posX/posY.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_SEC  = 3,
    parameter int BLAST_SEC = 2,
    parameter int COORD_W   = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               load,
    input  logic               tick,
    input  logic               run,
    input  logic               chain,
    input  logic [COORD_W-1:0] loadX,
    input  logic [COORD_W-1:0] loadY,
    output logic               busy,
    output logic               lamp,
    output logic               blast,
    output logic [COORD_W-1:0] posX,
    output logic [COORD_W-1:0] posY
);

    localparam int CW = cntWidth(FUSE_SEC, BLAST_SEC);

    slotState_t      state;
    logic [CW-1:0]   cnt;
    logic            phase;
    logic            pulse;
    logic            chainGo;
    logic            lastSec;

    // Pauses freeze both the countdown and chain reactions.
    assign pulse   = tick & run;
    assign chainGo = chain & run;
    assign lastSec = (cnt == CW'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            cnt   <= '0;
            phase <= 1'b0;
            posX  <= '0;
            posY  <= '0;
        end else if (load) begin
            // A fresh bomb never takes the same-cycle tick.
            state <= ARMED;
            cnt   <= CW'(FUSE_SEC);
            phase <= 1'b1;
            posX  <= loadX;
            posY  <= loadY;
        end else begin
            case (state)
                ARMED: begin
                    if (chainGo) begin
                        state <= BLAST;
                        cnt   <= CW'(BLAST_SEC);
                    end else if (pulse) begin
                        if (lastSec) begin
                            state <= BLAST;
                            cnt   <= CW'(BLAST_SEC);
                        end else begin
                            cnt   <= cnt - CW'(1);
                            phase <= ~phase;
                        end
                    end
                end
                BLAST: begin
                    if (pulse) begin
                        if (lastSec) state <= IDLE;
                        else         cnt   <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign blast = (state == BLAST);
    // Steady lamp in the final fuse second and throughout the blast.
    assign lamp  = blast | ((state == ARMED) & (phase | lastSec));

endmodule

// File: rtl/bomb_manager.sv
// bomb_manager: NUM_BOMBS bomb slots, lowest-free allocator, place-button
// edge detector and global RUNNING/PAUSED/RESUME mode FSM.
// Ports: clk, resetN, OneSecPulse, placeN, placeX/placeY, waitN, chainHit
//   -> placeAck, placeFull, bombActive, bombLamp, bombBlast, bombX/bombY.
// Option: define BOMB_CHAIN_EN to let chainHit detonate armed slots.
module bomb_manager
    import bomb_pkg::*;
#(
    parameter int NUM_BOMBS   = 4,
    parameter int FUSE_SEC    = 3,
    parameter int BLAST_SEC   = 2,
    parameter int PAUSE_DELAY = 7,
    parameter int COORD_W     = 4
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         OneSecPulse,
    input  logic                         placeN,
    input  logic [COORD_W-1:0]           placeX,
    input  logic [COORD_W-1:0]           placeY,
    input  logic                         waitN,
    input  logic [NUM_BOMBS-1:0]         chainHit,
    output logic                         placeAck,
    output logic                         placeFull,
    output logic [NUM_BOMBS-1:0]         bombActive,
    output logic [NUM_BOMBS-1:0]         bombLamp,
    output logic [NUM_BOMBS-1:0]         bombBlast,
    output logic [NUM_BOMBS*COORD_W-1:0] bombX,
    output logic [NUM_BOMBS*COORD_W-1:0] bombY
);

    localparam int DW = (PAUSE_DELAY > 0) ? $clog2(PAUSE_DELAY + 1) : 1;

    mode_t                mode;
    logic [DW-1:0]        delayCnt;
    logic                 placeNPrev;
    logic                 running;
    logic                 request;
    logic                 found;
    logic [NUM_BOMBS-1:0] load;
    logic [NUM_BOMBS-1:0] chain;
    logic [NUM_BOMBS-1:0] slotLamp;

    assign running = (mode == RUNNING);
    assign request = running & ~placeN & placeNPrev;

`ifdef BOMB_CHAIN_EN
    assign chain = chainHit;
`else
    logic unusedChain;
    assign chain       = '0;
    assign unusedChain = ^chainHit;
`endif

    // Lowest-index idle slot wins; busy reflects registered state, so a
    // slot expiring this cycle is not yet free.
    always_comb begin
        load  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (!bombActive[i] && !found) begin
                load[i] = request;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mode       <= RUNNING;
            delayCnt   <= '0;
            placeNPrev <= 1'b1;
            placeAck   <= 1'b0;
        end else begin
            placeNPrev <= placeN;
            placeAck   <= |load;
            case (mode)
                RUNNING: if (!waitN) mode <= PAUSED;
                PAUSED: begin
                    if (waitN) begin
                        mode     <= (PAUSE_DELAY == 0) ? RUNNING : RESUME;
                        delayCnt <= '0;
                    end
                end
                RESUME: begin
                    if (!waitN)
                        mode <= PAUSED;
                    else if (delayCnt == DW'(PAUSE_DELAY))
                        mode <= RUNNING;
                    else if (OneSecPulse)
                        delayCnt <= delayCnt + DW'(1);
                end
                default: mode <= RUNNING;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BOMBS; i++) begin : gSlot
        bomb_slot #(
            .FUSE_SEC (FUSE_SEC),
            .BLAST_SEC(BLAST_SEC),
            .COORD_W  (COORD_W)
        ) uSlot (
            .clk   (clk),
            .resetN(resetN),
            .load  (load[i]),
            .tick  (OneSecPulse),
            .run   (running),
            .chain (chain[i]),
            .loadX (placeX),
            .loadY (placeY),
            .busy  (bombActive[i]),
            .lamp  (slotLamp[i]),
            .blast (bombBlast[i]),
            .posX  (bombX[i*COORD_W +: COORD_W]),
            .posY  (bombY[i*COORD_W +: COORD_W])
        );
    end

    assign placeFull = &bombActive;
    // Dark screen during the resume countdown.
    assign bombLamp  = slotLamp & {NUM_BOMBS{mode != RESUME}};

endmodule

// File: tb/tb_bomb_manager.sv
// tb_bomb_manager: self-checking bench for bomb_manager (default params).
// Table-driven fuse/blast vectors plus hand-written corner sequences.
module tb_bomb_manager;

    localparam int NB = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              OneSecPulse = 1'b0;
    logic              placeN = 1'b1;
    logic [CW-1:0]     placeX = '0;
    logic [CW-1:0]     placeY = '0;
    logic              waitN = 1'b1;
    logic [NB-1:0]     chainHit = '0;
    logic              placeAck;
    logic              placeFull;
    logic [NB-1:0]     bombActive;
    logic [NB-1:0]     bombLamp;
    logic [NB-1:0]     bombBlast;
    logic [NB*CW-1:0]  bombX;
    logic [NB*CW-1:0]  bombY;

    int passCnt  = 0;
    int totalCnt = 0;

    typedef struct {
        logic          pulse;
        logic [NB-1:0] lamp;
        logic [NB-1:0] blast;
        logic [NB-1:0] active;
    } vec_t;
    vec_t vecs[7];

    typedef struct {
        logic          ack;
        logic [NB-1:0] active;
    } sb_t;
    sb_t sbq[$];

    bomb_manager dut (
        .clk        (clk),
        .resetN     (resetN),
        .OneSecPulse(OneSecPulse),
        .placeN     (placeN),
        .placeX     (placeX),
        .placeY     (placeY),
        .waitN      (waitN),
        .chainHit   (chainHit),
        .placeAck   (placeAck),
        .placeFull  (placeFull),
        .bombActive (bombActive),
        .bombLamp   (bombLamp),
        .bombBlast  (bombBlast),
        .bombX      (bombX),
        .bombY      (bombY)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        totalCnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        else
            passCnt++;
    endtask

    task automatic pulse();
        OneSecPulse = 1'b1;
        cyc();
        OneSecPulse = 1'b0;
    endtask

    task automatic scoreCheck(input string nm);
        sb_t e;
        e = sbq.pop_front();
        chk({nm, "Ack"}, placeAck, e.ack);
        chk({nm, "Active"}, bombActive, e.active);
    endtask

    task automatic request(input logic [CW-1:0] x, input logic [CW-1:0] y,
                           input logic expAck, input logic [NB-1:0] expAct);
        placeX = x;
        placeY = y;
        placeN = 1'b0;
        sbq.push_back('{expAck, expAct});
        cyc();
        scoreCheck("req");
        placeN = 1'b1;
        cyc();
        chk("ackFall", placeAck, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0001};
        vecs[1] = '{1'b0, 4'b0000, 4'b0000, 4'b0001};
        vecs[2] = '{1'b1, 4'b0001, 4'b0000, 4'b0001};
        vecs[3] = '{1'b0, 4'b0001, 4'b0000, 4'b0001};
        vecs[4] = '{1'b1, 4'b0001, 4'b0001, 4'b0001};
        vecs[5] = '{1'b1, 4'b0001, 4'b0001, 4'b0001};
        vecs[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};

        // Reset state
        cyc();
        cyc();
        chk("rstAck", placeAck, 0);
        chk("rstFull", placeFull, 0);
        chk("rstActive", bombActive, 0);
        chk("rstLamp", bombLamp, 0);
        chk("rstBlast", bombBlast, 0);
        chk("rstX", bombX, 0);
        chk("rstY", bombY, 0);
        resetN = 1'b1;
        cyc();

        // Single bomb lifecycle at (3,5)
        request(4'd3, 4'd5, 1'b1, 4'b0001);
        chk("lampEntry", bombLamp, 4'b0001);
        chk("x0", bombX[3:0], 3);
        chk("y0", bombY[3:0], 5);
        for (int i = 0; i < 7; i++) begin
            OneSecPulse = vecs[i].pulse;
            cyc();
            OneSecPulse = 1'b0;
            chk($sformatf("vecLamp%0d", i), bombLamp, vecs[i].lamp);
            chk($sformatf("vecBlast%0d", i), bombBlast, vecs[i].blast);
            chk($sformatf("vecActive%0d", i), bombActive, vecs[i].active);
        end

        // Fill all slots, fifth request dropped
        request(4'd1, 4'd1, 1'b1, 4'b0001);
        request(4'd2, 4'd2, 1'b1, 4'b0011);
        request(4'd3, 4'd3, 1'b1, 4'b0111);
        chk("notFull", placeFull, 0);
        request(4'd4, 4'd4, 1'b1, 4'b1111);
        chk("full", placeFull, 1);
        request(4'd5, 4'd5, 1'b0, 4'b1111);
        chk("fullX", bombX, 16'h4321);
        chk("fullY", bombY, 16'h4321);

        // Pause with fuse at 3, lamps on
        waitN = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            pulse();
            chk($sformatf("pauseLamp%0d", i), bombLamp, 4'b1111);
            chk($sformatf("pauseBlast%0d", i), bombBlast, 4'b0000);
        end
        waitN = 1'b1;
        cyc();
        chk("resumeDark", bombLamp, 4'b0000);
        for (int i = 0; i < 7; i++) begin
            pulse();
            chk($sformatf("resumeLamp%0d", i), bombLamp, 4'b0000);
        end
        cyc();
        chk("runLamp", bombLamp, 4'b1111);
        pulse();
        chk("afterLamp1", bombLamp, 4'b0000);
        pulse();
        chk("afterLamp2", bombLamp, 4'b1111);
        chk("afterBlast2", bombBlast, 4'b0000);
        pulse();
        chk("afterBlast3", bombBlast, 4'b1111);

        // Asynchronous reset during blast
        resetN = 1'b0;
        #1;
        chk("arstActive", bombActive, 0);
        chk("arstBlast", bombBlast, 0);
        chk("arstLamp", bombLamp, 0);
        chk("arstFull", placeFull, 0);
        chk("arstX", bombX, 0);
        cyc();
        resetN = 1'b1;
        cyc();
        request(4'd7, 4'd7, 1'b1, 4'b0001);

        // Slot 0 expires while a request arrives with all busy
        pulse();
        pulse();
        pulse();
        chk("s0Blast", bombBlast, 4'b0001);
        request(4'd1, 4'd1, 1'b1, 4'b0011);
        request(4'd2, 4'd2, 1'b1, 4'b0111);
        request(4'd3, 4'd3, 1'b1, 4'b1111);
        pulse();
        chk("s0Last", bombBlast, 4'b0001);
        placeX = 4'd8;
        placeN = 1'b0;
        OneSecPulse = 1'b1;
        sbq.push_back('{1'b0, 4'b1110});
        cyc();
        OneSecPulse = 1'b0;
        scoreCheck("expiry");
        placeN = 1'b1;
        cyc();
        chk("freeAfter", placeFull, 0);
        request(4'd9, 4'd9, 1'b1, 4'b1111);
        chk("reuseX", bombX[3:0], 9);

        // Chain hit on armed slot 1
        chainHit = 4'b0010;
        cyc();
        chainHit = 4'b0000;
`ifdef BOMB_CHAIN_EN
        chk("chainBlast", bombBlast, 4'b0010);
`else
        chk("chainBlast", bombBlast, 4'b0000);
`endif
        chk("chainActive", bombActive, 4'b1111);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
